fft_frame_feeder: RTL
=====================

// Module: fft_frame_feeder
// PURPOSE
//  Transmit-side feeder for the 2048-point FFT core: accepts complex samples from an upstream
//  valid/ready stream and buffers one full frame. It then drives the core's in_valid/D_re/D_im
//  as one gap-free burst of FRAME_LEN cycles. It watches the core's out_valid so that a new
//  frame does not launch before the previous transform has drained.
// PARAMETERS
//  FRAME_LEN  2048  samples per frame (power of 2)
//  ADDR_W     11    log2(FRAME_LEN)
//  DW         16    sample width, signed two's complement (re and im each)
// PORTS
//  clk          in   1      single clock, all logic rising-edge
//  rst_n        in   1      synchronous, active-low reset
//  s_valid      in   1      upstream sample valid
//  s_ready      out  1      feeder accepts the sample this cycle
//  s_re         in   DW     upstream real part
//  s_im         in   DW     upstream imaginary part
//  out_valid    in   1      FFT core output strobe (monitored only)
//  in_valid     out  1      to FFT core: sample valid, FRAME_LEN contiguous cycles
//  D_re         out  DW     to FFT core: real part
//  D_im         out  DW     to FFT core: imaginary part
//  frames_sent  out  16     count of completed bursts, wraps 0xFFFF->0
//  err_unexp    out  1      sticky: out_valid seen while no frame outstanding
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=FILL; wr/rd ptrs=0; s_ready=0, in_valid=0, D_re=D_im=0,
//   frames_sent=0, err_unexp=0, out-count=0, outstanding=0.
//   Mid-burst reset drops in_valid on the next edge. The partial frame is discarded.
//  FILL: s_ready=1 (from the first cycle after reset release).
//   Each s_valid&&s_ready cycle writes buf[wr_ptr] and increments wr_ptr.
//   The write of sample FRAME_LEN-1 moves to SEND. s_ready is registered and drops on that same edge.
//  SEND: s_ready=0. rd_ptr walks 0..FRAME_LEN-1. The buffer read is 1 cycle; D_re/D_im/in_valid are registered.
//   First in_valid is the 2nd edge after the last write. in_valid is high for exactly FRAME_LEN consecutive cycles.
//   D_re/D_im equal buffer contents in write order, with no reordering or scaling. They return to 0 when in_valid=0.
//   After the last beat: frames_sent++ and outstanding=1, then go to WAIT_OUT.
//  WAIT_OUT: s_ready=0. Counts out_valid cycles (ADDR_W+1-bit counter).
//   When FRAME_LEN strobes have been seen: outstanding=0, counter=0, go to FILL.
//   out_valid gaps are allowed and do not reset the count.
//  out_valid while outstanding=0 and state!=SEND: set err_unexp. The strobe is not counted.
//  If s_valid is held across SEND/WAIT_OUT, no sample is taken (s_ready=0). Upstream must hold data.
//  A simultaneous final out_valid and FILL entry: the write may start on the first FILL cycle.
// CONFIGURATION
//  FFT_FEED_OVERLAP_EN defined: WAIT_OUT is skipped and SEND returns directly to FILL.
//   Up to 2 frames may be outstanding (2-bit counter). Each FRAME_LEN out_valid strobes retire one.
//   FILL blocks (s_ready=0) while 2 are outstanding.
//   err_unexp sets when a strobe arrives with 0 outstanding.
//  Not defined: strict single-frame flow as described in BEHAVIOUR.
// STRUCTURE
//  Shared package/header fft_pkg: FRAME_LEN, ADDR_W, DW, and state encoding FILL=2'd0, SEND=2'd1, WAIT_OUT=2'd2.
//  One sub-module: fft_feed_ram, a 1W1R synchronous RAM of FRAME_LEN x (2*DW) with registered read.
//  FSM, pointers and counters live in the top.
// TESTING
//  1 Reset then 2048 samples re=i, im=-i -> in_valid 2048 contiguous cycles, D_re=i, D_im=-i; frames_sent=1.
//  2 Upstream s_valid toggling 50% during FILL -> the burst is still gap-free; data order intact.
//  3 After a burst, out_valid for 2047 cycles -> s_ready stays 0. On the 2048th strobe -> s_ready=1 the next cycle.
//  4 out_valid pulsed in FILL with nothing outstanding -> err_unexp=1, stays 1 until reset.
//  5 rst_n=0 at burst beat 100 -> in_valid=0, D=0 the next cycle. A new full frame is needed before the next burst.
//  6 OVERLAP_EN: 3 frames offered with no out_valid -> 2 bursts are sent, s_ready=0.
//    2048 strobes -> the third frame is accepted.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared constants, state encoding and sample type for the
//            FFT frame feeder and its buffer RAM.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Frame geometry and sample width
  localparam int FRAME_LEN = 2048;
  localparam int ADDR_W    = 11;
  localparam int DW        = 16;
  localparam int FRAMES_W  = 16;

  // Feeder state encoding
  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SEND     = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  // One complex sample as stored in the frame buffer (real part in the upper half)
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  // True when a buffer address points at the final sample of a frame
  function automatic logic is_last_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(FRAME_LEN - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_feed_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_feed_ram
// Brief    : Simple dual-port (1W1R) synchronous RAM holding one frame.
//            Read data is registered: it appears one edge after i_rd_en.
// Revision : 1.0 - initial release
// ============================================================================
module fft_feed_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: storage has no reset, contents are only meaningful once written
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered output, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_feeder
// Brief    : Buffers one full frame of complex samples from an upstream
//            valid/ready stream, then plays it to the FFT core as a single
//            gap-free in_valid burst. Watches the core's out_valid strobes
//            so a new frame is not launched before the previous transform
//            has drained.
//            Build option FFT_FEED_OVERLAP_EN: skip the drain wait and allow
//            up to two frames in flight inside the core.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_feeder
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_re,
  input  logic [DW-1:0]       s_im,
  input  logic                out_valid,
  output logic                in_valid,
  output logic [DW-1:0]       D_re,
  output logic [DW-1:0]       D_im,
  output logic [FRAMES_W-1:0] frames_sent,
  output logic                err_unexp
);

`ifdef FFT_FEED_OVERLAP_EN
  // Two transforms may be in flight; FILL stalls once both slots are taken
  localparam logic [1:0] c_max_outst = 2'd2;
`else
  // Strict flow: at most one transform in flight, and FILL only runs with none
  localparam logic [1:0] c_max_outst = 2'd1;
`endif

  localparam logic [ADDR_W:0] c_last_strobe = (ADDR_W+1)'(FRAME_LEN - 1);

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Pointers and read pipeline
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_rd_busy;   // read addresses still being issued
  logic              r_rd_vld;    // RAM output register holds a beat
  logic              r_rd_last;   // ... and it is the final beat
  logic              r_d_last;    // final beat currently on D_re/D_im

  // Output registers
  logic              r_s_ready;
  logic              r_in_valid;
  logic [DW-1:0]     r_d_re;
  logic [DW-1:0]     r_d_im;

  // Bookkeeping
  logic [FRAMES_W-1:0] r_frames;
  logic [ADDR_W:0]     r_out_cnt;
  logic [1:0]          r_outst;
  logic                r_err;

  // Combinational helpers
  logic              w_wr_fire;
  logic              w_fill_done;
  logic              w_rd_fire;
  logic              w_burst_done;
  logic              w_strobe_cnt;
  logic              w_retire;
  logic              w_unexp;
  logic [1:0]        w_outst_nxt;
  logic              w_s_ready_nxt;
  logic [2*DW-1:0]   w_rd_word;
  sample_t           w_rd_data;
  sample_t           w_wr_data;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  assign w_wr_fire    = s_valid & r_s_ready;
  assign w_fill_done  = w_wr_fire & is_last_addr(r_wr_ptr);
  assign w_rd_fire    = r_rd_busy;
  assign w_burst_done = r_d_last;

  // Strobes only count toward retiring a frame when one is actually in flight
  assign w_strobe_cnt = out_valid & (r_outst != 2'd0);
  assign w_retire     = w_strobe_cnt & (r_out_cnt == c_last_strobe);

`ifdef FFT_FEED_OVERLAP_EN
  assign w_unexp = out_valid & (r_outst == 2'd0);
`else
  // A strobe during SEND is tolerated: the core may emit while being loaded
  assign w_unexp = out_valid & (r_outst == 2'd0) & (r_state != SEND);
`endif

  // Outstanding-frame count after this edge: a burst end and a retire may coincide
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_burst_done && !w_retire) begin
      w_outst_nxt = r_outst + 2'd1;
    end else if (!w_burst_done && w_retire) begin
      w_outst_nxt = r_outst - 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the registered-ready request derived from it
  always_comb begin
    w_state_nxt   = r_state;
    w_s_ready_nxt = 1'b0;
    case (r_state)
      FILL: begin
        if (w_fill_done) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_burst_done) begin
`ifdef FFT_FEED_OVERLAP_EN
          w_state_nxt = FILL;
`else
          w_state_nxt = WAIT_OUT;
`endif
        end
      end
      WAIT_OUT: begin
        if (w_retire) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
    // s_ready is registered, so it is computed from where the FSM is going
    w_s_ready_nxt = (w_state_nxt == FILL) && (w_outst_nxt < c_max_outst);
  end

  // Registered upstream ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer
  // --------------------------------------------------------------------------
  // Write pointer: wraps to 0 on the final sample, ready for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  assign w_wr_data.re = s_re;
  assign w_wr_data.im = s_im;

  fft_feed_ram #(
    .DEPTH (FRAME_LEN),
    .AW    (ADDR_W),
    .WIDTH (2*DW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_fire),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_word)
  );

  assign w_rd_data = sample_t'(w_rd_word);

  // Read issue: one address per cycle from the edge that completes the fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_busy <= 1'b0;
      r_rd_ptr  <= '0;
    end else begin
      if (w_fill_done) begin
        r_rd_busy <= 1'b1;
      end else if (r_rd_busy && is_last_addr(r_rd_ptr)) begin
        r_rd_busy <= 1'b0;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Read pipeline tags follow the data through the RAM and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_d_last  <= 1'b0;
    end else begin
      r_rd_vld  <= w_rd_fire;
      r_rd_last <= w_rd_fire & is_last_addr(r_rd_ptr);
      r_d_last  <= r_rd_last;
    end
  end

  // Core-side outputs: data is forced to zero whenever in_valid is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_d_re     <= '0;
      r_d_im     <= '0;
    end else begin
      r_in_valid <= r_rd_vld;
      r_d_re     <= r_rd_vld ? w_rd_data.re : '0;
      r_d_im     <= r_rd_vld ? w_rd_data.im : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Frame accounting and error flag
  // --------------------------------------------------------------------------
  // Completed-burst counter, outstanding frames and the out_valid strobe counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frames  <= '0;
      r_outst   <= 2'd0;
      r_out_cnt <= '0;
    end else begin
      if (w_burst_done) begin
        r_frames <= r_frames + 1'b1;
      end
      r_outst <= w_outst_nxt;
      if (w_retire) begin
        r_out_cnt <= '0;
      end else if (w_strobe_cnt) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  // Sticky unexpected-strobe flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_unexp) begin
      r_err <= 1'b1;
    end
  end

  assign s_ready     = r_s_ready;
  assign in_valid    = r_in_valid;
  assign D_re        = r_d_re;
  assign D_im        = r_d_im;
  assign frames_sent = r_frames;
  assign err_unexp   = r_err;

endmodule
`default_nettype wire
